// File: rtl/alu_iter.sv
// alu_iter: multi-cycle W-bit ALU between the register file read ports and its write port.
// Latency: logic/arith and zero-count shifts 1 cycle; shifts 1+min(InB,W) cycles; MUL W+1 cycles.
// Backpressure: Start is sampled only while idle; a Start seen while busy is dropped, not queued.
// Ports: Clk/Reset (sync, active-high); Start/Op/InA/InB request; Busy, Done(=WriteEn) pulse,
//        Result/Carry/Zero registered and updated only on the Done cycle.
module alu_iter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic         Busy,
  output logic         Done,
  output logic         WriteEn,
  output logic [W-1:0] Result,
  output logic         Carry,
  output logic         Zero
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   sh_q;     // shifting operand, or the multiplicand for MUL
  logic [W-1:0]   mul_lo;   // multiplier, filled from the top with product low bits
  logic [W-1:0]   acc;      // product high half
  logic [CW-1:0]  cnt;

  // Single-cycle results computed straight from the request
  logic [W:0]     sum_ab;
  logic [W:0]     dif_ab;
  logic [CW-1:0]  k;
  logic           is_shift;
  logic [W-1:0]   imm_res;
  logic           imm_c;

  // One iteration of the shift / shift-add step
  logic [W:0]     acc_add;
  logic [W-1:0]   acc_nxt;
  logic [W-1:0]   lo_nxt;
  logic [W-1:0]   sh_nxt;
  logic           sh_cout;

  always_comb begin
    sum_ab   = {1'b0, InA} + {1'b0, InB};
    dif_ab   = {1'b0, InA} - {1'b0, InB};   // bit W is the borrow
    k        = (InB >= W[W-1:0]) ? CW'(W) : InB[CW-1:0];
    is_shift = (Op == OP_SHL) || (Op == OP_SHR);
    imm_res  = InA;
    imm_c    = 1'b0;
    case (Op)
      OP_ADD:  begin imm_res = sum_ab[W-1:0]; imm_c = sum_ab[W]; end
      OP_SUB:  begin imm_res = dif_ab[W-1:0]; imm_c = dif_ab[W]; end
      OP_AND:  imm_res = InA & InB;
      OP_OR:   imm_res = InA | InB;
      OP_XOR:  imm_res = InA ^ InB;
      default: imm_res = InA;               // zero-count shift passes A through
    endcase
  end

  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then shift the
    // {carry, acc, mul_lo} chain right by one.
    acc_add = {1'b0, acc} + (mul_lo[0] ? {1'b0, sh_q} : '0);
    acc_nxt = acc_add[W:1];
    lo_nxt  = {acc_add[0], mul_lo[W-1:1]};
    if (op_q == OP_SHL) begin
      sh_nxt  = {sh_q[W-2:0], 1'b0};
      sh_cout = sh_q[W-1];
    end else begin
      sh_nxt  = {1'b0, sh_q[W-1:1]};
      sh_cout = sh_q[0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      sh_q    <= '0;
      mul_lo  <= '0;
      acc     <= '0;
      cnt     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      WriteEn <= 1'b0;
      Result  <= '0;
      Carry   <= 1'b0;
      Zero    <= 1'b0;   // cleared on reset even though Result is zero
    end else begin
      Done    <= 1'b0;
      WriteEn <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q   <= Op;
            sh_q   <= InA;
            mul_lo <= InB;
            acc    <= '0;
            Busy   <= 1'b1;
            if (Op == OP_MUL) begin
              cnt   <= CW'(W);
              state <= RUN;
            end else if (is_shift && (k != '0)) begin
              cnt   <= k;
              state <= RUN;
            end else begin
              state   <= DONE;
              Done    <= 1'b1;
              WriteEn <= 1'b1;
              Result  <= imm_res;
              Carry   <= imm_c;
              Zero    <= (imm_res == '0);
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            acc    <= acc_nxt;
            mul_lo <= lo_nxt;
          end else begin
            sh_q <= sh_nxt;
          end
          if (cnt == CW'(1)) begin
            state   <= DONE;
            Done    <= 1'b1;
            WriteEn <= 1'b1;
            if (op_q == OP_MUL) begin
              Result <= lo_nxt;
              Carry  <= (acc_nxt != '0);
              Zero   <= (lo_nxt == '0);
            end else begin
              Result <= sh_nxt;
              Carry  <= sh_cout;
              Zero   <= (sh_nxt == '0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Multi-cycle 8-bit ALU that sits directly downstream of the register file. It takes the register file's two fixed read ports (r0 on InA, r1 on InB) and computes one result per Start, iterating shifts and multiplies one bit per cycle. It returns the result to the register file's DataIn with a one-cycle WriteEn strobe, and also drives Carry/Zero flags to branch logic.

## Interface
- W, 8, data width; all datapaths, Result and the internal accumulator are W bits.
- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Start  input  1  request; sampled only when Busy==0.
- Op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- InA  input  W  operand A (register file DataOutA).
- InB  input  W  operand B / shift amount (register file DataOutB).
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; Result/Carry/Zero are valid from this cycle.
- WriteEn  output  1  identical to Done; drives register file WriteEn.
- Result  output  W  registered result; holds until the next Done.
- Carry  output  1  registered flag; updated only at Done.
- Zero  output  1  registered flag, Result==0; updated only at Done.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + Start: latch InA, InB and Op into internal registers. Operands are never re-sampled after this.
  - Logic/arith ops and shifts with k=0 go to DONE.
  - Other shifts and MUL go to RUN.
- Shift count k = min(InB, W), so any InB >= 8 gives k=8. MUL always runs 8 iterations.
- RUN: one iteration per cycle, with a down-counter. On the last iteration go to DONE.
- DONE: Done=WriteEn=1 for exactly one cycle; Result, Carry and Zero are loaded this cycle. Next state is IDLE unconditionally.
- Start during RUN or DONE is ignored. It is not queued.
- Arithmetic (all results mod 2^W):
  - ADD: Carry = bit W of A+B.
  - SUB: Carry = borrow (A<B unsigned).
  - AND/OR/XOR: Carry=0.
  - SHL/SHR: logical, zero fill. Carry = last bit shifted out; 0 when k=0. Result = A when k=0.
  - MUL: shift-add over a 2W-bit product. Result = low byte; Carry = 1 iff high byte != 0.
- Zero = (Result == 0) for every op.
- Reset (any state, including mid-RUN):
  - Next cycle is IDLE, and the in-flight op is discarded.
  - Busy=Done=WriteEn=0; Result=0x00; Carry=0; Zero=0.
  - No Done is ever issued for an op interrupted by reset.
  - Reset has priority over Start in the same cycle.

## Timing
- Start accepted at edge N:
  - single-cycle ops: Done at cycle N+1.
  - shifts: Done at N+1+k.
  - MUL: Done at N+9.
- Busy rises the cycle after acceptance and falls the cycle after Done. Earliest next accepted Start is cycle Done+1, i.e. 2-cycle minimum throughput.
- Done and WriteEn are asserted only in DONE, never combinationally from Start.
- Outputs are all registered, with no combinational path from inputs to outputs.
- The register file captures Result on the edge ending the Done cycle; the integrator must have Waddr valid during that cycle.

## Test plan
- ADD InA=0xF0, InB=0x20, Start at N -> Done/WriteEn high at N+1 only, Result=0x10, Carry=1, Zero=0. Busy high N+1, low N+2.
- SUB 0x05-0x07 -> Result=0xFE, Carry=1. SUB 0x07-0x07 -> Result=0x00, Carry=0, Zero=1.
- SHL InA=0x81, InB=3 -> Done at N+4, Result=0x08, Carry=0.
- SHR InA=0x81, InB=0x0C (clamped to k=8) -> Done at N+9, Result=0x00, Carry=1, Zero=1.
- SHL InA=0x5A, InB=0 -> Done at N+1, Result=0x5A, Carry=0.
- MUL 0x10*0x11 -> Done at N+9, Result=0x10, Carry=1. Start pulsed at N+3 with other operands is ignored; the next op is accepted at N+10.
- Reset at N+4 of a MUL -> from N+5: Busy=0, Result=0x00, flags 0, and no Done through N+12. A fresh ADD 0x01+0x01 then gives 0x02.
